// File: rtl/bw_tsr_mon_if.sv
// Signal bundle between the thermal-sensor back end and its configuration/consumer side.
// The master drives the sensor code and settings; the slave (the monitor) returns results.
interface bw_tsr_mon_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned PER_W = 10
);
    logic             mon_en;
    logic [DW-1:0]    tsr_dout;
    logic [PER_W-1:0] sample_period;
    logic [DW-1:0]    hot_code;
    logic [DW-1:0]    cool_code;
    logic             clr_min;
    logic [DW-1:0]    temp_avg;
    logic             temp_vld;
    logic [DW-1:0]    temp_min;
    logic             hot_alarm;
    logic             glitch_err;

    modport master (
        output mon_en, tsr_dout, sample_period, hot_code, cool_code, clr_min,
        input  temp_avg, temp_vld, temp_min, hot_alarm, glitch_err
    );

    modport slave (
        input  mon_en, tsr_dout, sample_period, hot_code, cool_code, clr_min,
        output temp_avg, temp_vld, temp_min, hot_alarm, glitch_err
    );
endinterface

// File: rtl/bw_tsr_mon.sv
// Thermal sensor back end: synchronises the raw code, captures stable samples periodically,
// averages them, tracks the hottest (minimum) average and drives a hysteretic hot alarm.
module bw_tsr_mon #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned PER_W    = 10
) (
    input logic         clk,
    input logic         reset,
    bw_tsr_mon_if.slave mon
);
    localparam int unsigned ACC_W = DW + AVG_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StCapt} state_e;

    state_e              state_q, state_d;
    logic [DW-1:0]       s1_q, s2_q, s3_q;
    logic [PER_W-1:0]    per_q, per_d, per_load;
    logic [1:0]          retry_q, retry_d;
    logic [ACC_W-1:0]    acc_q, acc_sum;
    logic [AVG_LOG2-1:0] cnt_q;
    logic                accept, glitch_set;
    logic [DW-1:0]       avg_q, min_q;
    logic                vld_q, hot_q, gerr_q;

    // Periods of 0 and 1 behave as 2, so the counter always loads at least 1.
    always_comb begin
        per_load = (mon.sample_period < PER_W'(2)) ? PER_W'(1)
                                                   : mon.sample_period - PER_W'(1);
        acc_sum  = acc_q + ACC_W'(s2_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '1;
            s2_q <= '1;
            s3_q <= '1;
        end else begin
            s1_q <= mon.tsr_dout;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            per_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        per_d      = per_q;
        retry_d    = retry_q;
        accept     = 1'b0;
        glitch_set = 1'b0;
        if (!mon.mon_en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StWait;
                    per_d   = per_load;
                end
                StWait: begin
                    if (per_q == '0) begin
                        state_d = StCapt;
                        retry_d = '0;
                    end else begin
                        per_d = per_q - PER_W'(1);
                    end
                end
                StCapt: begin
                    if (s2_q == s3_q) begin
                        accept  = 1'b1;
                        state_d = StWait;
                        per_d   = per_load;
                    end else if (retry_q == 2'd2) begin
                        glitch_set = 1'b1;
                        state_d    = StWait;
                        per_d      = per_load;
                    end else begin
                        retry_d = retry_q + 2'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            avg_q  <= '1;
            vld_q  <= 1'b0;
            min_q  <= '1;
            hot_q  <= 1'b0;
            gerr_q <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (!mon.mon_en) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (accept) begin
                if (cnt_q == '1) begin
                    avg_q <= acc_sum[ACC_W-1:AVG_LOG2];
                    vld_q <= 1'b1;
                    acc_q <= '0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + AVG_LOG2'(1);
                end
            end
            if (glitch_set) begin
                gerr_q <= 1'b1;
            end
            // Peak-hold and alarm act in the cycle temp_vld is high, on the fresh average.
            if (vld_q) begin
                if (mon.clr_min || (avg_q < min_q)) begin
                    min_q <= avg_q;
                end
                // With hot_code >= cool_code this reduces to avg <= hot_code.
                if (avg_q <= mon.hot_code) begin
                    hot_q <= 1'b1;
                end else if (avg_q >= mon.cool_code) begin
                    hot_q <= 1'b0;
                end
            end else if (mon.clr_min) begin
                min_q <= '1;
            end
        end
    end

    assign mon.temp_avg   = avg_q;
    assign mon.temp_vld   = vld_q;
    assign mon.temp_min   = min_q;
    assign mon.hot_alarm  = hot_q;
    assign mon.glitch_err = gerr_q;
endmodule
